// File: rtl/dbus_arb_pkg.sv
// Shared types and constants for the two-master data-bus arbiter.
package dbus_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

    localparam int PRIO_RR    = 0;
    localparam int PRIO_FIXED = 1;

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way picker: round-robin against the last-served index, or fixed m0 priority.
module rr_arb2
    import dbus_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    input  logic       mode,
    output logic       gnt
);

    // NOTE: every output of an always_comb gets a default first so no path can infer a latch.
    always_comb begin
        gnt = M0;
        if (req == 2'b11) begin
            gnt = mode ? M0 : ~last;
        end else if (req[1]) begin
            gnt = M1;
        end
    end

endmodule

// File: rtl/dbus_arbiter.sv
// Serialises two masters onto one registered slave data port with a window check.
// Optional statistics counters are enabled by defining DBUS_ARB_STATS_EN.
module dbus_arbiter
    import dbus_arb_pkg::*;
#(
    parameter int          PRIO_MODE = 0,
    parameter logic [31:0] WIN_BASE  = 32'h0000_0000,
    parameter int          WIN_BITS  = 16
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        m0_req,
    input  logic        m0_wen,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_done,
    output logic        m0_err,
    output logic [31:0] m0_rdata,

    input  logic        m1_req,
    input  logic        m1_wen,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_done,
    output logic        m1_err,
    output logic [31:0] m1_rdata,

    output logic        s_wen,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    input  logic [31:0] s_rdata
`ifdef DBUS_ARB_STATS_EN
    ,
    output logic [31:0] stat_m0,
    output logic [31:0] stat_m1,
    output logic [15:0] stat_err
`endif
);

    state_t      state, state_next;
    logic        sel_r;
    logic        last_r;
    logic        wen_r;
    logic        hit_r;
    logic [31:0] addr_r;
    logic [31:0] wdata_r;
    logic [31:0] rdata0_r, rdata1_r;

    logic [1:0]  req_vec;
    logic        gnt;
    logic [31:0] pick_addr;
    logic        grant;

    // Byte-lane bits are dropped before the window check and the slave access.
    logic        unused_addr_lsbs;
    assign unused_addr_lsbs = ^{m0_addr[1:0], m1_addr[1:0]};

    // Unsigned offset compared in 33 bits so a full 32-bit window does not overflow.
    function automatic logic in_window(input logic [31:0] a);
        logic [32:0] off;
        off = {1'b0, a - WIN_BASE};
        return off < (33'd1 << WIN_BITS);
    endfunction

    assign req_vec   = {m1_req, m0_req};
    assign grant     = (state == IDLE) && (|req_vec);
    assign pick_addr = (gnt == M1) ? {m1_addr[31:2], 2'b00} : {m0_addr[31:2], 2'b00};

    rr_arb2 u_pick (
        .req  (req_vec),
        .last (last_r),
        .mode (PRIO_MODE == PRIO_FIXED),
        .gnt  (gnt)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (|req_vec) state_next = ACCESS;
            ACCESS:  state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: the transaction registers are plain flops (not memories), so they are all reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_r    <= M0;
            last_r   <= M1;
            wen_r    <= 1'b0;
            hit_r    <= 1'b0;
            addr_r   <= '0;
            wdata_r  <= '0;
            rdata0_r <= '0;
            rdata1_r <= '0;
        end else begin
            if (grant) begin
                sel_r   <= gnt;
                last_r  <= gnt;
                wen_r   <= (gnt == M1) ? m1_wen   : m0_wen;
                wdata_r <= (gnt == M1) ? m1_wdata : m0_wdata;
                addr_r  <= pick_addr;
                hit_r   <= in_window(pick_addr);
            end
            if (state == ACCESS) begin
                if (sel_r == M1) rdata1_r <= (hit_r && !wen_r) ? s_rdata : '0;
                else             rdata0_r <= (hit_r && !wen_r) ? s_rdata : '0;
            end
        end
    end

    // Decoded from state so an asynchronous reset removes the write strobe at once.
    assign s_wen    = (state == ACCESS) && wen_r && hit_r;
    assign s_addr   = addr_r;
    assign s_wdata  = wdata_r;

    assign m0_done  = (state == DONE) && (sel_r == M0);
    assign m1_done  = (state == DONE) && (sel_r == M1);
    assign m0_err   = m0_done && !hit_r;
    assign m1_err   = m1_done && !hit_r;
    assign m0_rdata = rdata0_r;
    assign m1_rdata = rdata1_r;

`ifdef DBUS_ARB_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_m0  <= '0;
            stat_m1  <= '0;
            stat_err <= '0;
        end else if (state == DONE) begin
            if (sel_r == M1) stat_m1 <= stat_m1 + 32'd1;
            else             stat_m0 <= stat_m0 + 32'd1;
            if (!hit_r)      stat_err <= stat_err + 16'd1;
        end
    end
`endif

endmodule
